// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit slice sequenced LSB nibble first, carry registered
// between nibbles. Define NIBBLE_ADD_SUB_EN to add the op_sub port (A - B).
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            accept, last, release_result;
  logic [4:0]      slice;
  logic            b_inv, c0;

  assign accept         = (state == IDLE) && in_valid && !reset;
  assign last           = (idx == IW'(N - 1));
  assign release_result = (state == DONE) && out_ready;

`ifdef NIBBLE_ADD_SUB_EN
  assign b_inv = op_sub;
  assign c0    = op_sub ? 1'b1 : cin;
`else
  assign b_inv = 1'b0;
  assign c0    = cin;
`endif

  // The 4-bit slice: nibble of A plus nibble of effective B plus registered carry.
  assign slice = {1'b0, a_r[idx*4 +: 4]} + {1'b0, b_r[idx*4 +: 4]} + {4'b0, carry};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // b_r keeps the effective B so overflow can be derived from stored operands alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b_inv ? ~b : b;
      sum_r <= '0;
      carry <= c0;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_r[idx*4 +: 4] <= slice[3:0];
      carry             <= slice[4];
      if (!last) idx <= idx + 1'b1;
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE) && !release_result ? 1'b1 : (state == DONE);
  assign sum       = sum_r;
  assign cout      = (state == DONE) && carry;
  assign ovf       = (state == DONE) && (a_r[WIDTH-1] == b_r[WIDTH-1])
                     && (sum_r[WIDTH-1] != a_r[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench: WIDTH=8 and WIDTH=32 controllers checked against plain-arithmetic expectations.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b1;          // 1 = drive/observe the WIDTH=8 instance
  logic        iv = 1'b0, ordy = 1'b0, c_in = 1'b0, sub = 1'b0;
  logic [31:0] a_bus = '0, b_bus = '0;
  int          checks = 0, failures = 0;

  logic        ir8, ov8, co8, of8, ir32, ov32, co32, of32;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic        o_ready, o_valid, o_cout, o_ovf;
  logic [31:0] o_sum;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv & sel), .in_ready(ir8),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(c_in),
`ifdef NIBBLE_ADD_SUB_EN
    .op_sub(sub),
`endif
    .out_valid(ov8), .out_ready(ordy & sel), .sum(s8), .cout(co8), .ovf(of8));

  nibble_serial_adder_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(iv & ~sel), .in_ready(ir32),
    .a(a_bus), .b(b_bus), .cin(c_in),
`ifdef NIBBLE_ADD_SUB_EN
    .op_sub(sub),
`endif
    .out_valid(ov32), .out_ready(ordy & ~sel), .sum(s32), .cout(co32), .ovf(of32));

  assign o_ready = sel ? ir8  : ir32;
  assign o_valid = sel ? ov8  : ov32;
  assign o_sum   = sel ? {24'b0, s8} : s32;
  assign o_cout  = sel ? co8  : co32;
  assign o_ovf   = sel ? of8  : of32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the selected instance, with `hold` stalled cycles in DONE.
  task automatic op(input bit w8, input logic [31:0] av, input logic [31:0] bv,
                    input bit cv, input bit sv, input int hold);
    int          w, n, lat;
    logic [63:0] m, be, full, es;
    bit          ec, eo;
    w    = w8 ? 8 : 32;
    n    = w / 4;
    m    = (64'd1 << w) - 1;
`ifdef NIBBLE_ADD_SUB_EN
    be   = sv ? (~{32'b0, bv} & m) : ({32'b0, bv} & m);
    full = ({32'b0, av} & m) + be + (sv ? 64'd1 : {63'b0, cv});
`else
    be   = {32'b0, bv} & m;
    full = ({32'b0, av} & m) + be + {63'b0, cv};
`endif
    es = full & m;
    ec = full[w];
    eo = (av[w-1] == be[w-1]) && (es[w-1] != av[w-1]);

    sel = w8; a_bus = av; b_bus = bv; c_in = cv; sub = sv;
    #1;
    check("in_ready_idle", o_ready, 1);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    a_bus = $urandom; b_bus = $urandom; c_in = $urandom; sub = $urandom;
    lat = 0;
    while (!o_valid && lat < 100) begin
      check("in_ready_busy", o_ready, 0);
      iv = $urandom;
      tick();
      lat++;
    end
    iv = 1'b0;
    check("latency", lat, n);
    check("sum", o_sum, es);
    check("cout", o_cout, ec);
    check("ovf", o_ovf, eo);
    for (int k = 0; k < hold; k++) begin
      iv = $urandom;
      tick();
      check("hold_valid", o_valid, 1);
      check("hold_sum", o_sum, es);
      check("hold_in_ready", o_ready, 0);
    end
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    check("consumed_valid", o_valid, 0);
    check("next_in_ready", o_ready, 1);
  endtask

  initial begin
    sel = 1'b1;
    tick(); tick();
    check("rst_in_ready", o_ready, 0);
    check("rst_out_valid", o_valid, 0);
    check("rst_sum", o_sum, 0);
    check("rst_cout", o_cout, 0);
    check("rst_ovf", o_ovf, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", o_ready, 1);

    op(1, 32'hFF, 32'h01, 0, 0, 0);
    op(1, 32'h7F, 32'h01, 0, 0, 0);
    op(0, 32'h0FFF_FFFF, 32'h0000_0001, 1, 0, 0);
    op(0, 32'h8000_0000, 32'h8000_0000, 0, 0, 5);
`ifdef NIBBLE_ADD_SUB_EN
    op(1, 32'h05, 32'h07, 0, 1, 0);
`endif

    // Abort on the second RUN cycle.
    sel = 1'b0; a_bus = 32'h1234_5678; b_bus = 32'h1111_1111; c_in = 1'b0; sub = 1'b0;
    iv = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_out_valid", o_valid, 0);
    check("abort_sum", o_sum, 0);
    check("abort_in_ready", o_ready, 0);
    reset = 1'b0;
    #1;
    check("abort_idle", o_ready, 1);
    op(0, 32'hDEAD_BEEF, 32'h0123_4567, 1, 0, 1);

    for (int i = 0; i < 24; i++) begin
      bit sv;
`ifdef NIBBLE_ADD_SUB_EN
      sv = 1'($urandom);
`else
      sv = 1'b0;
`endif
      op(1'($urandom), $urandom, $urandom, 1'($urandom), sv, int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
